// File: rtl/perceptron_pkg.sv
// Shared types and defaults for the perceptron training datapath.
// Holds the feeder state encoding and the sample bundle layout.
package perceptron_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 64;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    LOADED,
    TRAIN
  } feederState_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] x1;
    logic [DEF_DATA_W-1:0] x2;
    logic [DEF_DATA_W-1:0] t;
  } sample_t;

endpackage

// File: rtl/sample_ram.sv
// Sample store: one write port, one synchronous read port.
// Contents are not reset; the read register only moves on re.
module sample_ram #(
  parameter int WIDTH  = 96,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/training_sample_feeder.sv
// Buffers a host training set and replays it to the perceptron controller.
// Optional epoch counter output: define FEEDER_EPOCH_CNT_EN.
module training_sample_feeder
  import perceptron_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_last,
  input  logic [DATA_W-1:0] wr_x1,
  input  logic [DATA_W-1:0] wr_x2,
  input  logic [DATA_W-1:0] wr_t,
  input  logic              train_go,
  output logic              start,
  output logic [31:0]       n_bus,
  input  logic              ready_to_get_data,
  input  logic              reinit,
  input  logic              done_signal,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] x2,
  output logic [DATA_W-1:0] t,
  output logic              sample_valid,
  output logic              busy,
  output logic              loaded
`ifdef FEEDER_EPOCH_CNT_EN
  ,
  output logic [15:0]       epoch_cnt
`endif
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  feederState_t state, stateNext;
  logic [CW-1:0] wrPtr, wrPtrNext;
  logic [CW-1:0] count, countNext;
  logic [ADDR_W-1:0] rdPtr, rdPtrNext;
  logic [ADDR_W-1:0] rdAddr, wrAddr;
  logic wrEn, rdEn, wrOpen;
  logic startNext, startQ, validQ, haveData;
  logic [3*DATA_W-1:0] rdData;

  function automatic logic [ADDR_W-1:0] nextPtr(
    input logic [ADDR_W-1:0] p,
    input logic [CW-1:0]     cnt
  );
    return ({1'b0, p} == cnt - 1'b1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    stateNext = state;
    wrPtrNext = wrPtr;
    countNext = count;
    rdPtrNext = rdPtr;
    wrEn      = 1'b0;
    wrAddr    = wrPtr[ADDR_W-1:0];
    rdEn      = 1'b0;
    rdAddr    = rdPtr;
    startNext = 1'b0;
    wrOpen    = 1'b0;
    unique case (state)
      EMPTY: begin
        wrOpen = 1'b1;
        if (wr_valid) begin
          wrEn      = 1'b1;
          wrAddr    = '0;
          wrPtrNext = CW'(1);
          if (wr_last) begin
            countNext = CW'(1);
            stateNext = LOADED;
          end else begin
            stateNext = LOAD;
          end
        end
      end
      LOAD: begin
        wrOpen = (wrPtr < FULL);
        if (wr_valid) begin
          if (wrOpen) begin
            wrEn      = 1'b1;
            wrPtrNext = wrPtr + 1'b1;
          end
          // A last strobe on a full buffer still closes the set.
          if (wr_last) begin
            countNext = wrOpen ? wrPtr + 1'b1 : FULL;
            stateNext = LOADED;
          end
        end
      end
      LOADED: begin
        if (train_go) begin
          rdPtrNext = '0;
          startNext = 1'b1;
          stateNext = TRAIN;
        end else if (wr_valid && wr_last) begin
          wrEn      = 1'b1;
          wrAddr    = '0;
          wrPtrNext = CW'(1);
          stateNext = LOAD;
        end
      end
      TRAIN: begin
        if (done_signal) begin
          stateNext = LOADED;
        end else if (reinit) begin
          rdAddr    = '0;
          rdEn      = ready_to_get_data;
          rdPtrNext = ready_to_get_data ? nextPtr('0, count) : '0;
        end else if (ready_to_get_data) begin
          rdEn      = 1'b1;
          rdPtrNext = nextPtr(rdPtr, count);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      wrPtr    <= '0;
      count    <= '0;
      rdPtr    <= '0;
      startQ   <= 1'b0;
      validQ   <= 1'b0;
      haveData <= 1'b0;
    end else begin
      state    <= stateNext;
      wrPtr    <= wrPtrNext;
      count    <= countNext;
      rdPtr    <= rdPtrNext;
      startQ   <= startNext;
      validQ   <= rdEn;
      haveData <= haveData | rdEn;
    end
  end

  sample_ram #(
    .WIDTH (3*DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) uRam (
    .clk  (clk),
    .we   (wrEn),
    .waddr(wrAddr),
    .wdata({wr_x1, wr_x2, wr_t}),
    .re   (rdEn),
    .raddr(rdAddr),
    .rdata(rdData)
  );

  // RAM is not reset, so mask its register until a real delivery.
  assign x1 = haveData ? rdData[3*DATA_W-1 -: DATA_W] : '0;
  assign x2 = haveData ? rdData[2*DATA_W-1 -: DATA_W] : '0;
  assign t  = haveData ? rdData[DATA_W-1:0] : '0;

  assign sample_valid = validQ;
  assign start        = startQ;
  assign busy         = (state == TRAIN);
  assign loaded       = (state == LOADED);
  assign n_bus        = (busy || loaded) ? 32'(count) : 32'd0;
  assign wr_ready     = rst_n & wrOpen;

`ifdef FEEDER_EPOCH_CNT_EN
  logic [15:0] epochQ;
  logic        lastWrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      epochQ   <= '0;
      lastWrap <= 1'b0;
    end else begin
      if (state == LOADED && train_go)
        epochQ <= '0;
      else if (state == TRAIN && reinit && epochQ != 16'hFFFF)
        epochQ <= epochQ + 1'b1;
      if (rdEn) lastWrap <= (rdPtrNext == '0);
    end
  end

  assign epoch_cnt = epochQ;
`endif

endmodule

// File: tb/tb_training_sample_feeder.sv
// Directed bench for training_sample_feeder with a queue-based model.
// Model checks every cycle; literal checks pin the model at key points.
module tb_training_sample_feeder;
  import perceptron_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int DP = DEF_DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_valid = 1'b0;
  logic wr_last = 1'b0;
  logic train_go = 1'b0;
  logic ready = 1'b0;
  logic reinit = 1'b0;
  logic done_signal = 1'b0;
  logic [DW-1:0] wr_x1 = '0;
  logic [DW-1:0] wr_x2 = '0;
  logic [DW-1:0] wr_t = '0;
  logic wr_ready, start, sample_valid, busy, loaded;
  logic [31:0] n_bus;
  logic [DW-1:0] x1, x2, t;
`ifdef FEEDER_EPOCH_CNT_EN
  logic [15:0] epoch_cnt;
`endif

  int cmpCnt = 0;
  int errCnt = 0;

  always #5 clk = ~clk;

  training_sample_feeder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .wr_last          (wr_last),
    .wr_x1            (wr_x1),
    .wr_x2            (wr_x2),
    .wr_t             (wr_t),
    .train_go         (train_go),
    .start            (start),
    .n_bus            (n_bus),
    .ready_to_get_data(ready),
    .reinit           (reinit),
    .done_signal      (done_signal),
    .x1               (x1),
    .x2               (x2),
    .t                (t),
    .sample_valid     (sample_valid),
    .busy             (busy),
    .loaded           (loaded)
`ifdef FEEDER_EPOCH_CNT_EN
    ,
    .epoch_cnt        (epoch_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    cmpCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: a growing queue becomes the set on the last write.
  sample_t build[$];
  sample_t set[$];
  sample_t cur;
  sample_t eOut;
  int idx;
  bit haveSet, training, eStart, eValid;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      build.delete();
      set.delete();
      idx = 0;
      haveSet = 0;
      training = 0;
      eStart = 0;
      eValid = 0;
      eOut = '0;
    end else begin
      eStart = 0;
      eValid = 0;
      cur = {wr_x1, wr_x2, wr_t};
      if (training) begin
        if (done_signal) begin
          training = 0;
        end else if (reinit) begin
          idx = 0;
          if (ready) begin
            eOut = set[0];
            eValid = 1;
            idx = 1 % set.size();
          end
        end else if (ready) begin
          eOut = set[idx];
          eValid = 1;
          idx = (idx + 1) % set.size();
        end
      end else if (haveSet) begin
        if (train_go) begin
          training = 1;
          idx = 0;
          eStart = 1;
        end else if (wr_valid && wr_last) begin
          haveSet = 0;
          set.delete();
          build.delete();
          build.push_back(cur);
        end
      end else if (wr_valid) begin
        if (build.size() < DP) build.push_back(cur);
        if (wr_last) begin
          set = build;
          build.delete();
          haveSet = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("wr_ready", wr_ready,
        32'(rst_n && !haveSet && build.size() < DP));
    chk("start", start, 32'(eStart));
    chk("sample_valid", sample_valid, 32'(eValid));
    chk("busy", busy, 32'(training));
    chk("loaded", loaded, 32'(haveSet && !training));
    chk("n_bus", n_bus, haveSet ? 32'(set.size()) : 32'd0);
    chk("x1", x1, eOut.x1);
    chk("x2", x2, eOut.x2);
    chk("t", t, eOut.t);
  end

  function automatic sample_t mk(input int a, input int b, input int c);
    sample_t s;
    s.x1 = a;
    s.x2 = b;
    s.t  = c;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input sample_t s, input bit last);
    wr_valid = 1'b1;
    wr_last = last;
    wr_x1 = s.x1;
    wr_x2 = s.x2;
    wr_t = s.t;
    step();
    wr_valid = 1'b0;
    wr_last = 1'b0;
  endtask

  task automatic go();
    train_go = 1'b1;
    step();
    train_go = 1'b0;
    chk("lit_start_hi", start, 32'd1);
    chk("lit_busy", busy, 32'd1);
    step();
    chk("lit_start_lo", start, 32'd0);
  endtask

  task automatic reqChk(input sample_t e);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("lit_sv", sample_valid, 32'd1);
    chk("lit_x1", x1, e.x1);
    chk("lit_x2", x2, e.x2);
    chk("lit_t", t, e.t);
  endtask

  task automatic pulseDone();
    done_signal = 1'b1;
    step();
    done_signal = 1'b0;
  endtask

  initial begin
    sample_t pat[4];
    int seq[6];
    pat[0] = mk(1, 1, 1);
    pat[1] = mk(1, -1, -1);
    pat[2] = mk(-1, 1, -1);
    pat[3] = mk(-1, -1, -1);
    seq = '{0, 1, 2, 3, 0, 1};

    step();
    step();
    chk("lit_rst_wr_ready", wr_ready, 32'd0);
    chk("lit_rst_x1", x1, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("lit_empty_wr_ready", wr_ready, 32'd1);

    for (int i = 0; i < 4; i++) wr(pat[i], i == 3);
    chk("lit_loaded", loaded, 32'd1);
    chk("lit_n4", n_bus, 32'd4);
    go();
    chk("lit_n4_train", n_bus, 32'd4);

    for (int i = 0; i < 6; i++) reqChk(pat[seq[i]]);

    reqChk(pat[2]);
    reqChk(pat[3]);
    reinit = 1'b1;
    ready = 1'b1;
    step();
    reinit = 1'b0;
    ready = 1'b0;
    chk("lit_reinit_x2", x2, pat[0].x2);
    chk("lit_reinit_sv", sample_valid, 32'd1);
    reqChk(pat[1]);
    reinit = 1'b1;
    step();
    reinit = 1'b0;
    chk("lit_reinit_only_sv", sample_valid, 32'd0);
    reqChk(pat[0]);

    ready = 1'b1;
    pulseDone();
    ready = 1'b0;
    chk("lit_done_busy", busy, 32'd0);
    chk("lit_done_loaded", loaded, 32'd1);
    chk("lit_done_sv", sample_valid, 32'd0);
    chk("lit_done_n", n_bus, 32'd4);
    go();
    reqChk(pat[0]);
    reqChk(pat[1]);

    pulseDone();
    wr(pat[2], 1'b1);
    chk("lit_clear_loaded", loaded, 32'd0);
    chk("lit_clear_n", n_bus, 32'd0);
    wr(pat[3], 1'b1);
    chk("lit_reload_n", n_bus, 32'd2);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 70; i++) begin
      if (i == 63) chk("lit_wr_ready_63", wr_ready, 32'd1);
      wr(mk(i, -i, 3 * i), i == 69);
      if (i == 63) chk("lit_wr_ready_full", wr_ready, 32'd0);
    end
    chk("lit_n64", n_bus, 32'd64);
    go();
    for (int k = 0; k < 66; k++) begin
      int j;
      j = k % 64;
      reqChk(mk(j, -j, 3 * j));
    end

    for (int i = 0; i < 3; i++) begin
      reinit = 1'b1;
      step();
      reinit = 1'b0;
      step();
    end
`ifdef FEEDER_EPOCH_CNT_EN
    chk("lit_epoch3", 32'(epoch_cnt), 32'd3);
`endif
    reqChk(mk(0, 0, 0));
    reqChk(mk(1, -1, 3));

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("lit_async_busy", busy, 32'd0);
    chk("lit_async_loaded", loaded, 32'd0);
    chk("lit_async_n", n_bus, 32'd0);
    chk("lit_async_x1", x1, 32'd0);
    chk("lit_async_t", t, 32'd0);
    chk("lit_async_sv", sample_valid, 32'd0);
    chk("lit_async_wr_ready", wr_ready, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("lit_after_rst_wr_ready", wr_ready, 32'd1);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmpCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/training_sample_feeder.md
Name: training_sample_feeder

Overview:
- Upstream stage of the perceptron training controller.
- Buffers a training set of N samples (x1, x2, t) written by the host, then launches training and supplies the count N on n_bus.
- Replays one sample per readyToGetData request and wraps at the end of each epoch.
- Rewinds to sample 0 on the controller's reinitializing indication; returns to the loaded state on doneSignal.

Parameters:
- DATA_W, 32, width of x1, x2 and t (two's complement).
- DEPTH, 64, maximum samples stored.
- ADDR_W, 6, $clog2(DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  host sample write strobe.
- wr_ready  out  1  feeder accepts a write this cycle.
- wr_last  in  1  marks the final sample of the set; qualified by wr_valid.
- wr_x1, wr_x2, wr_t  in  DATA_W  sample fields.
- train_go  in  1  host request to start training.
- start  out  1  one-cycle start pulse to the controller.
- n_bus  out  32  stored sample count N, zero-extended.
- ready_to_get_data  in  1  controller requests the next sample.
- reinit  in  1  controller reinitializingState.
- done_signal  in  1  controller doneSignal.
- x1, x2, t  out  DATA_W  presented sample.
- sample_valid  out  1  x1/x2/t were updated this cycle.
- busy  out  1  high in TRAIN.
- loaded  out  1  a non-empty set is held.

Behaviour:
- Reset (asynchronous):
  - state = EMPTY; wr_ptr, rd_ptr and count = 0.
  - x1, x2, t = 0.
  - start, sample_valid, busy, loaded = 0; wr_ready = 0.
  - RAM contents are undefined.
- States:
  - EMPTY: wr_ready = 1. The first accepted write moves to LOAD, or directly to LOADED if wr_last is set.
  - LOAD: wr_ready = (wr_ptr < DEPTH). Each accepted write stores to wr_ptr and increments wr_ptr. On an accepted wr_last: count = wr_ptr + 1, go to LOADED.
  - LOADED: loaded = 1; wr_ready = 0.
    - On train_go: rd_ptr = 0, start = 1 for exactly one cycle, go to TRAIN.
    - A wr_valid+wr_last with train_go low clears the set: wr_ptr = 0, the sample is written as entry 0, go to LOAD.
  - TRAIN: busy = 1; writes are refused (wr_ready = 0).
- Buffer full: in LOAD with wr_ptr == DEPTH, wr_ready = 0 and writes are dropped. wr_last is still honoured when wr_valid is high, giving count = DEPTH.
- n_bus:
  - Driven from count in LOADED and TRAIN; 0 otherwise.
  - Stable from the cycle start rises, because the controller samples N during its initializing state.
- Sample delivery:
  - ready_to_get_data high at edge k causes x1/x2/t = mem[rd_ptr] and sample_valid = 1 in the cycle after edge k. This is exactly the controller's getData cycle. Latency is 1 cycle; no stall.
  - After each delivery: rd_ptr = (rd_ptr == count-1) ? 0 : rd_ptr + 1. Wrap-around is silent.
  - The outputs hold their last value when no request is made.
- Simultaneous events:
  - reinit with ready_to_get_data: reinit has priority; mem[0] is delivered and rd_ptr = 1 (0 if count == 1).
  - reinit alone: rd_ptr = 0 with no delivery.
  - done_signal: go to LOADED and keep the data; a pending request in the same cycle is ignored.
- Ignored inputs:
  - ready_to_get_data and reinit are ignored outside TRAIN.
  - train_go is ignored outside LOADED.
- Reset mid-TRAIN: everything returns to EMPTY and the stored set is lost.
- Read path: synchronous RAM read; the address is selected combinationally from the request and reinit so the data lands in one cycle.

Optional Feature:
- Macro: FEEDER_EPOCH_CNT_EN.
- With the macro defined:
  - Extra output epoch_cnt [15:0] and register last_wrap.
  - epoch_cnt clears on train_go, increments (saturating at 0xFFFF) on each reinit in TRAIN, and holds its value in LOADED.
- Without it: no epoch_cnt port or logic; all other behaviour is identical.

Decomposition:
- Package perceptron_pkg holds:
  - DATA_W and DEPTH defaults;
  - the feeder state enum {EMPTY, LOAD, LOADED, TRAIN};
  - a sample_t struct {x1, x2, t}.
- Sub-module sample_ram: single write port, single synchronous read port, DEPTH x 3*DATA_W, no reset.

Test Plan:
1. Write 4 samples ((1,1,1),(1,-1,-1),(-1,1,-1),(-1,-1,-1)) with wr_last on the 4th, then pulse train_go -> loaded = 1, a single-cycle start, n_bus = 4.
2. Pulse ready_to_get_data 6 times -> delivered samples 0,1,2,3,0,1, each with sample_valid one cycle after the request.
3. After 2 deliveries, assert reinit together with ready_to_get_data -> sample 0 delivered; the next request delivers sample 1.
4. Write 70 samples with DEPTH = 64 -> wr_ready drops after 64 writes, wr_last gives n_bus = 64, deliveries wrap after index 63.
5. In TRAIN, pulse done_signal -> busy = 0, loaded = 1, data kept; a second train_go restarts at sample 0.
6. Deassert rst_n mid-TRAIN -> all outputs are 0 immediately (asynchronous), state EMPTY, n_bus = 0; with FEEDER_EPOCH_CNT_EN, 3 reinits before reset show epoch_cnt = 3.
